// File: rtl/regfile_cmd_ctrl_if.sv
// Command-sequencer bus: receive bytes in, register file access port,
// transmit handshake and status. The master side is the sequencer.
interface regfile_cmd_ctrl_if #(
  parameter int DATAWIDTH = 8,
  parameter int ADDR      = 4
);
  logic [DATAWIDTH-1:0] RX_P_DATA;
  logic                 RX_D_VLD;
  logic [ADDR-1:0]      Address;
  logic                 WrEn;
  logic                 RdEn;
  logic [DATAWIDTH-1:0] WrData;
  logic [DATAWIDTH-1:0] RdData;
  logic                 RdData_Valid;
  logic [DATAWIDTH-1:0] TX_P_DATA;
  logic                 TX_D_VLD;
  logic                 TX_BUSY;
  logic                 BUSY;
  logic                 CMD_ERR;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, TX_BUSY,
    output Address, WrEn, RdEn, WrData, TX_P_DATA, TX_D_VLD, BUSY, CMD_ERR
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, TX_BUSY,
    input  Address, WrEn, RdEn, WrData, TX_P_DATA, TX_D_VLD, BUSY, CMD_ERR
  );
endinterface

// File: rtl/regfile_cmd_ctrl.sv
// Byte-command sequencer owning the register file access port.
// Write frame: 0xAA, addr, data. Read frame: 0xBB, addr; read data is
// returned on the transmit handshake. All outputs are registered.
module regfile_cmd_ctrl #(
  parameter int DATAWIDTH  = 8,
  parameter int ADDR       = 4,
  parameter int RD_TIMEOUT = 4
) (
  input  logic               CLK,
  input  logic               RST,
  regfile_cmd_ctrl_if.master bus
);

  localparam logic [DATAWIDTH-1:0] CMD_WR = DATAWIDTH'(8'hAA);
  localparam logic [DATAWIDTH-1:0] CMD_RD = DATAWIDTH'(8'hBB);
  localparam int                   CW     = $clog2(RD_TIMEOUT + 1);
  localparam logic [CW-1:0]        TO_LAST = CW'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    WR_EXEC,
    RD_ADDR,
    RD_EXEC,
    RD_WAIT,
    TX_SEND
  } state_t;

  state_t        state;
  logic [CW-1:0] to_cnt;

  // Sequencer FSM; strobes default low and are raised on entry to the state
  // they belong to, so every output comes straight from a flop.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state        <= IDLE;
      to_cnt       <= '0;
      bus.Address  <= '0;
      bus.WrData   <= '0;
      bus.WrEn     <= 1'b0;
      bus.RdEn     <= 1'b0;
      bus.TX_P_DATA <= '0;
      bus.TX_D_VLD <= 1'b0;
      bus.BUSY     <= 1'b0;
      bus.CMD_ERR  <= 1'b0;
    end else begin
      bus.WrEn     <= 1'b0;
      bus.RdEn     <= 1'b0;
      bus.TX_D_VLD <= 1'b0;
      bus.CMD_ERR  <= 1'b0;

      // bytes arriving while an operation executes are dropped and flagged
      if (bus.RX_D_VLD && (state inside {WR_EXEC, RD_EXEC, RD_WAIT, TX_SEND}))
        bus.CMD_ERR <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.RX_D_VLD) begin
            if (bus.RX_P_DATA == CMD_WR)
              state <= WR_ADDR;
            else if (bus.RX_P_DATA == CMD_RD)
              state <= RD_ADDR;
            else
              bus.CMD_ERR <= 1'b1;
          end
        end

        WR_ADDR: begin
          if (bus.RX_D_VLD) begin
            bus.Address <= bus.RX_P_DATA[ADDR-1:0];
            state       <= WR_DATA;
          end
        end

        WR_DATA: begin
          if (bus.RX_D_VLD) begin
            bus.WrData <= bus.RX_P_DATA;
            bus.WrEn   <= 1'b1;
            bus.BUSY   <= 1'b1;
            state      <= WR_EXEC;
          end
        end

        WR_EXEC: begin
          bus.BUSY <= 1'b0;
          state    <= IDLE;
        end

        RD_ADDR: begin
          if (bus.RX_D_VLD) begin
            bus.Address <= bus.RX_P_DATA[ADDR-1:0];
            bus.RdEn    <= 1'b1;
            bus.BUSY    <= 1'b1;
            state       <= RD_EXEC;
          end
        end

        RD_EXEC: begin
          to_cnt <= '0;
          state  <= RD_WAIT;
        end

        RD_WAIT: begin
          if (bus.RdData_Valid) begin
            bus.TX_P_DATA <= bus.RdData;
            state         <= TX_SEND;
          end else if (to_cnt == TO_LAST) begin
            bus.CMD_ERR <= 1'b1;
            bus.BUSY    <= 1'b0;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + CW'(1);
          end
        end

        TX_SEND: begin
          if (!bus.TX_BUSY) begin
            bus.TX_D_VLD <= 1'b1;
            bus.BUSY     <= 1'b0;
            state        <= IDLE;
          end
        end

        default: begin
          bus.BUSY <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// Directed bench for regfile_cmd_ctrl with a small register file model.
module tb_regfile_cmd_ctrl;
  localparam int RD_TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_cmd_ctrl_if #(.DATAWIDTH(8), .ADDR(4)) bus ();

  regfile_cmd_ctrl #(.DATAWIDTH(8), .ADDR(4), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  // register file model: read data valid one cycle after RdEn
  logic [7:0] mem [16];
  logic       rf_respond;
  always @(posedge clk) begin
    if (bus.WrEn) mem[bus.Address] <= bus.WrData;
    bus.RdData_Valid <= bus.RdEn && rf_respond;
    bus.RdData       <= mem[bus.Address];
  end

  // edge counter: after posedge k it reads k
  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // strobe monitor
  int unsigned wr_cnt = 0, rd_cnt = 0, tx_cnt = 0, err_cnt = 0, both_cnt = 0;
  int unsigned wr_edge = 0, rd_edge = 0, tx_edge = 0, err_edge = 0;
  logic [3:0]  wr_addr = '0, rd_addr = '0;
  logic [7:0]  wr_data = '0, tx_data = '0;
  logic        wr_busy = 1'b0;
  always @(negedge clk) begin
    if (bus.WrEn) begin
      wr_cnt++; wr_addr = bus.Address; wr_data = bus.WrData;
      wr_edge = edge_cnt; wr_busy = bus.BUSY;
    end
    if (bus.RdEn) begin
      rd_cnt++; rd_addr = bus.Address; rd_edge = edge_cnt;
    end
    if (bus.TX_D_VLD) begin
      tx_cnt++; tx_data = bus.TX_P_DATA; tx_edge = edge_cnt;
    end
    if (bus.CMD_ERR) begin
      err_cnt++; err_edge = edge_cnt;
    end
    if (bus.WrEn && bus.RdEn) both_cnt++;
  end

  int unsigned n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // drive one byte, assumed called 1ns after an edge; returns its sample edge
  task automatic send_byte(input logic [7:0] b, output int unsigned at);
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    @(posedge clk); #1;
    bus.RX_D_VLD  = 1'b0;
    at = edge_cnt;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned n, m;
    int unsigned wr0, rd0, tx0, err0;

    rst = 1'b0;
    bus.RX_D_VLD  = 1'b0;
    bus.RX_P_DATA = '0;
    bus.TX_BUSY   = 1'b0;
    rf_respond    = 1'b1;
    idle(3);

    check("rst_address", bus.Address, 0);
    check("rst_wrdata", bus.WrData, 0);
    check("rst_wren", bus.WrEn, 0);
    check("rst_rden", bus.RdEn, 0);
    check("rst_txdata", bus.TX_P_DATA, 0);
    check("rst_txvld", bus.TX_D_VLD, 0);
    check("rst_busy", bus.BUSY, 0);
    check("rst_cmderr", bus.CMD_ERR, 0);
    rst = 1'b1;
    idle(1);

    // write AA 0A 88
    wr0 = wr_cnt; rd0 = rd_cnt; err0 = err_cnt;
    send_byte(8'hAA, n); send_byte(8'h0A, n); send_byte(8'h88, n);
    idle(3);
    check("wr_count", wr_cnt - wr0, 1);
    check("wr_addr", wr_addr, 4'hA);
    check("wr_data", wr_data, 8'h88);
    check("wr_timing", wr_edge, n);
    check("wr_busy", wr_busy, 1);
    check("wr_no_err", err_cnt - err0, 0);
    check("wr_no_rd", rd_cnt - rd0, 0);
    check("wr_mem", mem[4'hA], 8'h88);

    // write 8B to F, then read F starting in the first IDLE cycle
    wr0 = wr_cnt; rd0 = rd_cnt; tx0 = tx_cnt; err0 = err_cnt;
    send_byte(8'hAA, n); send_byte(8'h0F, n); send_byte(8'h8B, n);
    idle(1);
    send_byte(8'hBB, m); send_byte(8'h0F, m);
    idle(6);
    check("b2b_wr_count", wr_cnt - wr0, 1);
    check("rd_count", rd_cnt - rd0, 1);
    check("rd_addr", rd_addr, 4'hF);
    check("rd_timing", rd_edge, m);
    check("tx_count", tx_cnt - tx0, 1);
    check("tx_data", tx_data, 8'h8B);
    check("tx_timing", tx_edge, m + 3);
    check("rd_no_err", err_cnt - err0, 0);

    // backpressure on a read of A
    tx0 = tx_cnt; err0 = err_cnt;
    bus.TX_BUSY = 1'b1;
    send_byte(8'hBB, n); send_byte(8'h0A, n);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("bp_busy", bus.BUSY, 1);
    end
    check("bp_held", tx_cnt - tx0, 0);
    bus.TX_BUSY = 1'b0;
    idle(3);
    check("bp_tx_count", tx_cnt - tx0, 1);
    check("bp_tx_data", tx_data, 8'h88);
    check("bp_tx_timing", tx_edge, n + 6);
    check("bp_no_err", err_cnt - err0, 0);

    // bad command, then masked address
    wr0 = wr_cnt; rd0 = rd_cnt; tx0 = tx_cnt; err0 = err_cnt;
    send_byte(8'h55, n);
    idle(2);
    check("bad_err_count", err_cnt - err0, 1);
    check("bad_err_timing", err_edge, n);
    check("bad_no_wr", wr_cnt - wr0, 0);
    check("bad_no_rd", rd_cnt - rd0, 0);
    send_byte(8'hAA, n); send_byte(8'hF3, n); send_byte(8'h11, n);
    idle(3);
    check("mask_wr_count", wr_cnt - wr0, 1);
    check("mask_addr", wr_addr, 4'h3);
    check("mask_data", wr_data, 8'h11);
    check("mask_mem", mem[4'h3], 8'h11);

    // byte during WR_EXEC is dropped, write still completes
    wr0 = wr_cnt; err0 = err_cnt;
    send_byte(8'hAA, n); send_byte(8'h01, n); send_byte(8'h22, n);
    send_byte(8'h99, m);
    idle(3);
    check("drop_err_count", err_cnt - err0, 1);
    check("drop_err_timing", err_edge, n + 1);
    check("drop_wr_count", wr_cnt - wr0, 1);
    check("drop_wr_data", wr_data, 8'h22);

    // read timeout
    rd0 = rd_cnt; tx0 = tx_cnt; err0 = err_cnt;
    rf_respond = 1'b0;
    send_byte(8'hBB, n); send_byte(8'h02, n);
    idle(RD_TIMEOUT + 4);
    rf_respond = 1'b1;
    check("to_rd_count", rd_cnt - rd0, 1);
    check("to_rd_addr", rd_addr, 4'h2);
    check("to_err_count", err_cnt - err0, 1);
    check("to_err_timing", err_edge, n + RD_TIMEOUT + 1);
    check("to_no_tx", tx_cnt - tx0, 0);
    check("to_busy_low", bus.BUSY, 0);
    wr0 = wr_cnt;
    send_byte(8'hAA, n); send_byte(8'h04, n); send_byte(8'h5A, n);
    idle(3);
    check("to_idle_wr", wr_cnt - wr0, 1);
    check("to_idle_addr", wr_addr, 4'h4);

    // reset mid-frame
    wr0 = wr_cnt; err0 = err_cnt;
    send_byte(8'hAA, n); send_byte(8'h05, n);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    check("mid_rst_address", bus.Address, 0);
    send_byte(8'h77, n);
    idle(3);
    check("mid_rst_no_wr", wr_cnt - wr0, 0);
    check("mid_rst_err", err_cnt - err0, 1);
    check("mid_rst_err_timing", err_edge, n);

    check("wr_rd_exclusive", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
